// File: rtl/proc_control_if.sv
// proc_control_if: control-unit <-> datapath/memory bundle
// Ports (master = control unit):
//   in : run, mem_din[15:0], rx_zero
//   out: imm9[8:0], rx_addr[2:0], ry_addr[2:0], bus_sel[2:0], r_in[7:0],
//        a_in, g_in, alu_op[1:0], addr_in, dout_in, mem_wr, pc_inc, pc_in,
//        done, illegal
interface proc_control_if;
    logic        run;
    logic [15:0] mem_din;
    logic        rx_zero;
    logic [8:0]  imm9;
    logic [2:0]  rx_addr;
    logic [2:0]  ry_addr;
    logic [2:0]  bus_sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic        addr_in;
    logic        dout_in;
    logic        mem_wr;
    logic        pc_inc;
    logic        pc_in;
    logic        done;
    logic        illegal;
    modport master (
        input  run, mem_din, rx_zero,
        output imm9, rx_addr, ry_addr, bus_sel, r_in, a_in, g_in, alu_op,
               addr_in, dout_in, mem_wr, pc_inc, pc_in, done, illegal
    );
    modport slave (
        output run, mem_din, rx_zero,
        input  imm9, rx_addr, ry_addr, bus_sel, r_in, a_in, g_in, alu_op,
               addr_in, dout_in, mem_wr, pc_inc, pc_in, done, illegal
    );
endinterface

// File: rtl/proc_control.sv
// proc_control: multicycle fetch/decode/execute sequencer for the 16-bit processor
// Ports: clock, reset (async, active-high), cif (proc_control_if.master):
//   run/mem_din/rx_zero in; IR fields, bus select, register/ALU/memory/PC
//   strobes, done and illegal out. All outputs decode from state and IR.
module proc_control (
    input  logic           clock,
    input  logic           reset,
    proc_control_if.master cif
);
    typedef enum logic [2:0] {IDLE, FETCH, FWAIT, DECODE, E1, E2, E3} state_t;
    state_t      state, next;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [7:0]  rx_hot;
    logic        last;
    assign op          = ir[15:12];
    assign rx_hot      = 8'b1 << ir[11:9];
    assign cif.imm9    = ir[8:0];
    assign cif.rx_addr = ir[11:9];
    assign cif.ry_addr = ir[8:6];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= next;
            if (state == DECODE) ir <= cif.mem_din;
        end
    end
    always_comb begin
        next        = state;
        last        = 1'b0;
        cif.bus_sel = 3'd0;
        cif.r_in    = 8'd0;
        cif.a_in    = 1'b0;
        cif.g_in    = 1'b0;
        cif.alu_op  = 2'd0;
        cif.addr_in = 1'b0;
        cif.dout_in = 1'b0;
        cif.mem_wr  = 1'b0;
        cif.pc_inc  = 1'b0;
        cif.pc_in   = 1'b0;
        cif.illegal = 1'b0;
        case (state)
            IDLE:   next = cif.run ? FETCH : IDLE;
            FETCH: begin
                cif.bus_sel = 3'd6;
                cif.addr_in = 1'b1;
                cif.pc_inc  = 1'b1;
                next        = FWAIT;
            end
            FWAIT:  next = DECODE;
            DECODE: next = E1;
            E1: begin
                next = E2;
                case (op)
                    4'd0, 4'd1: begin
                        cif.bus_sel = (op == 4'd0) ? 3'd2 : 3'd3;
                        cif.r_in    = rx_hot;
                        last        = 1'b1;
                    end
                    4'd2, 4'd3, 4'd4: begin
                        cif.bus_sel = 3'd1;
                        cif.a_in    = 1'b1;
                    end
                    4'd5, 4'd6: begin
                        cif.bus_sel = 3'd2;
                        cif.addr_in = 1'b1;
                    end
                    // Taken branch adds imm to the already-incremented PC via A/G.
                    4'd7: begin
                        cif.bus_sel = cif.rx_zero ? 3'd6 : 3'd0;
                        cif.a_in    = cif.rx_zero;
                        last        = !cif.rx_zero;
                    end
                    default: begin
                        cif.illegal = 1'b1;
                        last        = 1'b1;
                    end
                endcase
            end
            E2: begin
                next = E3;
                case (op)
                    4'd2, 4'd3, 4'd4, 4'd7: begin
                        cif.bus_sel = (op == 4'd4 || op == 4'd7) ? 3'd3 : 3'd2;
                        cif.g_in    = 1'b1;
                        cif.alu_op  = (op == 4'd3) ? 2'd2 : 2'd1;
                    end
                    4'd6: begin
                        cif.bus_sel = 3'd1;
                        cif.dout_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            E3: begin
                last = 1'b1;
                case (op)
                    4'd2, 4'd3, 4'd4, 4'd5: begin
                        cif.bus_sel = (op == 4'd5) ? 3'd5 : 3'd4;
                        cif.r_in    = rx_hot;
                    end
                    4'd6: cif.mem_wr = 1'b1;
                    4'd7: begin
                        cif.bus_sel = 3'd4;
                        cif.pc_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: next = IDLE;
        endcase
        if (last) next = cif.run ? FETCH : IDLE;
        cif.done = last;
    end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed per-scenario checks of the proc_control sequencer
module tb_proc_control;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    proc_control_if cif ();
    proc_control dut (.clock(clock), .reset(reset), .cif(cif));

    always #5 clock = ~clock;

    // {bus_sel, r_in, a_in, g_in, alu_op, addr_in, dout_in, mem_wr, pc_inc, pc_in, done, illegal}
    function automatic logic [21:0] v(input int b, r, a, g, alu, ad, dn_in, wr, inc, pin, dn, il);
        return {b[2:0], r[7:0], a[0], g[0], alu[1:0], ad[0], dn_in[0], wr[0], inc[0], pin[0], dn[0], il[0]};
    endfunction

    function automatic logic [21:0] outs();
        return {cif.bus_sel, cif.r_in, cif.a_in, cif.g_in, cif.alu_op, cif.addr_in,
                cif.dout_in, cif.mem_wr, cif.pc_inc, cif.pc_in, cif.done, cif.illegal};
    endfunction

    localparam logic [21:0] Z = 22'd0;
    logic [21:0] f;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] e [0:4];
        e = '{f, Z, Z, v(1,0,1,0,0,0,0,0,0,0,0,0), v(2,0,0,1,1,0,0,0,0,0,0,0)};
        reset = 1'b1; cif.run = 1'b0; cif.mem_din = 16'h0; cif.rx_zero = 1'b0;
        step(); step();
        checks++;
        if (outs() !== Z) begin errors++; $display("FAIL reset_outs got %h expected %h", outs(), Z); end
        checks++;
        if ({cif.imm9, cif.rx_addr, cif.ry_addr} !== 15'd0) begin
            errors++; $display("FAIL reset_fields got %h expected 0", {cif.imm9, cif.rx_addr, cif.ry_addr});
        end
        reset = 1'b0;
        cif.mem_din = 16'h2280; cif.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) cif.run = 1'b0;
            checks++;
            if (outs() !== e[i]) begin errors++; $display("FAIL add_pre_reset cycle %0d got %h expected %h", i, outs(), e[i]); end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs() !== Z) begin errors++; $display("FAIL async_reset got %h expected %h", outs(), Z); end
        checks++;
        if ({cif.imm9, cif.rx_addr, cif.ry_addr} !== 15'd0) begin
            errors++; $display("FAIL async_reset_ir got %h expected 0", {cif.imm9, cif.rx_addr, cif.ry_addr});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs() !== Z) begin errors++; $display("FAIL reset_hold cycle %0d got %h expected %h", i, outs(), Z); end
        end
        reset = 1'b0; cif.run = 1'b1;
        step();
        checks++;
        if (outs() !== f) begin errors++; $display("FAIL restart_fetch got %h expected %h", outs(), f); end
        cif.run = 1'b0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_mvi();
        logic [21:0] e [0:4];
        e = '{f, Z, Z, v(3,8'h08,0,0,0,0,0,0,0,0,1,0), Z};
        cif.mem_din = 16'h17FE; cif.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) cif.run = 1'b0;
            checks++;
            if (outs() !== e[i]) begin errors++; $display("FAIL mvi cycle %0d got %h expected %h", i, outs(), e[i]); end
            if (i == 3) begin
                checks++;
                if (cif.imm9 !== 9'h1FE || cif.rx_addr !== 3'd3) begin
                    errors++; $display("FAIL mvi_fields got imm9=%h rx=%0d expected imm9=1fe rx=3", cif.imm9, cif.rx_addr);
                end
            end
        end
    endtask

    task automatic test_add();
        logic [21:0] e [0:6];
        e = '{f, Z, Z, v(1,0,1,0,0,0,0,0,0,0,0,0), v(2,0,0,1,1,0,0,0,0,0,0,0),
              v(4,8'h02,0,0,0,0,0,0,0,0,1,0), Z};
        cif.mem_din = 16'h2280; cif.run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) cif.run = 1'b0;
            checks++;
            if (outs() !== e[i]) begin errors++; $display("FAIL add cycle %0d got %h expected %h", i, outs(), e[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] e [0:12];
        e = '{f, Z, Z, v(2,0,0,0,0,1,0,0,0,0,0,0), Z, v(5,8'h10,0,0,0,0,0,0,0,0,1,0),
              f, Z, Z, v(2,0,0,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,1,0,0,0,0,0),
              v(0,0,0,0,0,0,0,1,0,0,1,0), Z};
        cif.mem_din = 16'h5940; cif.run = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 3) cif.mem_din = 16'h6940;
            if (i == 6) cif.run = 1'b0;
            checks++;
            if (outs() !== e[i]) begin errors++; $display("FAIL ld_st cycle %0d got %h expected %h", i, outs(), e[i]); end
        end
    endtask

    task automatic test_beqz();
        logic [21:0] e0 [0:4];
        logic [21:0] e1 [0:6];
        e0 = '{f, Z, Z, v(0,0,0,0,0,0,0,0,0,0,1,0), Z};
        e1 = '{f, Z, Z, v(6,0,1,0,0,0,0,0,0,0,0,0), v(3,0,0,1,1,0,0,0,0,0,0,0),
               v(4,0,0,0,0,0,0,0,0,1,1,0), Z};
        cif.mem_din = 16'h7005; cif.rx_zero = 1'b0; cif.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) cif.run = 1'b0;
            checks++;
            if (outs() !== e0[i]) begin errors++; $display("FAIL beqz_untaken cycle %0d got %h expected %h", i, outs(), e0[i]); end
        end
        cif.rx_zero = 1'b1; cif.run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) cif.run = 1'b0;
            checks++;
            if (outs() !== e1[i]) begin errors++; $display("FAIL beqz_taken cycle %0d got %h expected %h", i, outs(), e1[i]); end
            if (i == 4) begin
                checks++;
                if (cif.imm9 !== 9'h005) begin errors++; $display("FAIL beqz_imm got %h expected 005", cif.imm9); end
            end
        end
        cif.rx_zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [21:0] e [0:5];
        e = '{f, Z, Z, v(0,0,0,0,0,0,0,0,0,0,1,1), Z, Z};
        cif.mem_din = 16'hF000; cif.run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 1) cif.run = 1'b0;
            checks++;
            if (outs() !== e[i]) begin errors++; $display("FAIL illegal cycle %0d got %h expected %h", i, outs(), e[i]); end
        end
    endtask

    initial begin
        f = v(6,0,0,0,0,1,0,0,1,0,0,0);
        test_reset();
        test_mvi();
        test_add();
        test_back_to_back();
        test_beqz();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
